// File: rtl/trdb_packet_emitter.sv
// Trace packet emitter: packs format 1/2/3 trace packets into a flat payload bus
// with a byte length, registered one cycle after the request.
package trdb_pkg;
  localparam int unsigned XLEN             = 32;
  localparam int unsigned CAUSE_LEN        = 5;
  localparam int unsigned BRANCH_COUNT_LEN = 5;
  localparam int unsigned BRANCH_MAP_LEN   = 31;
  localparam int unsigned PAYLOAD_LEN      = 256;
  localparam int unsigned P_LEN            = 8;

  typedef enum logic [1:0] {
    F_UNSUPPORTED = 2'h0,
    F_BRANCH_FULL = 2'h1,
    F_ADDR_ONLY   = 2'h2,
    F_SYNC        = 2'h3
  } trdb_format_e;

  typedef enum logic [1:0] {
    SF_START   = 2'h0,
    SF_TRAP    = 2'h1,
    SF_CONTEXT = 2'h2,
    SF_SUPPORT = 2'h3
  } trdb_f_sync_subformat_e;

  typedef enum logic [1:0] {
    QS_NO_CHANGE  = 2'h0,
    QS_ENDED_REP  = 2'h1,
    QS_TRACE_LOST = 2'h2,
    QS_ENDED_NTR  = 2'h3
  } qual_status_e;

  typedef enum logic [2:0] {
    IOPT_DELTA        = 3'h0,
    IOPT_FULL         = 3'h1,
    IOPT_IMPLICIT_EXC = 3'h2,
    IOPT_SIJUMP       = 3'h3,
    IOPT_IMPLICIT_RET = 3'h4,
    IOPT_BRANCH_PRED  = 3'h5,
    IOPT_JUMP_CACHE   = 3'h6,
    IOPT_RESERVED     = 3'h7
  } ioptions_e;
endpackage

// Handshake: valid_i is a one-cycle request with no backpressure; packet_valid_o
// pulses for exactly one cycle, one clock later, carrying that request's packet.
module trdb_packet_emitter
  import trdb_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          valid_i,
  input  trdb_format_e                  packet_format_i,
  input  trdb_f_sync_subformat_e        packet_f_sync_subformat_i,
  input  logic [CAUSE_LEN-1:0]          lc_cause_i,
  input  logic [CAUSE_LEN-1:0]          tc_cause_i,
  input  logic [XLEN-1:0]               lc_tval_i,
  input  logic [XLEN-1:0]               tc_tval_i,
  input  logic                          lc_interrupt_i,
  input  logic                          tc_interrupt_i,
  input  logic                          lc_tc_mux_i,
  input  logic                          nocontext_i,
  input  logic                          notime_i,
  input  logic                          tc_branch_i,
  input  logic                          tc_branch_taken_i,
  input  logic [1:0]                    tc_priv_i,
  input  logic [XLEN-1:0]               tc_iaddr_i,
  input  logic                          thaddr_i,
  input  logic [XLEN-3:0]               tc_tvec_i,
  input  logic [XLEN-1:0]               lc_epc_i,
  input  logic                          tc_ienable_i,
  input  logic                          encoder_mode_i,
  input  qual_status_e                  qual_status_i,
  input  ioptions_e                     ioptions_i,
  input  logic                          lc_updiscon_i,
  input  logic [BRANCH_COUNT_LEN-1:0]   branches_i,
  input  logic [BRANCH_MAP_LEN-1:0]     branch_map_i,
  input  logic [$clog2(XLEN):0]         keep_bits_i,
  output logic                          packet_valid_o,
  output logic [PAYLOAD_LEN-1:0]        packet_payload_o,
  output logic [P_LEN-1:0]              payload_length_o,
  output logic                          branch_map_flush_o,
  output logic [XLEN-1:0]               addr_to_compress_o
);

  localparam int unsigned KW  = $clog2(XLEN) + 1;
  localparam int unsigned AW1 = XLEN + 1;
  localparam int unsigned MW1 = BRANCH_MAP_LEN + 1;

  logic [KW-1:0]             keep_eff;
  logic [AW1-1:0]            addr_mask_wide;
  logic [XLEN-1:0]           kept_addr;
  logic [P_LEN-1:0]          map_len;
  logic [MW1-1:0]            map_mask_wide;
  logic [BRANCH_MAP_LEN-1:0] map_bits;
  logic [CAUSE_LEN-1:0]      cause_sel;
  logic [XLEN-1:0]           tval_sel;
  logic                      interrupt_sel;
  logic [XLEN-1:0]           trap_addr;
  logic                      branch_bit;
  logic                      unused_ok;

  logic                      emit_d;
  logic                      flush_d;
  logic [PAYLOAD_LEN-1:0]    payload_d;
  logic [P_LEN-1:0]          bits_d;
  logic [P_LEN-1:0]          pos;

  // Context and time fields are never emitted, so these flags are ignored.
  assign unused_ok = ^{nocontext_i, notime_i, addr_mask_wide[XLEN], map_mask_wide[BRANCH_MAP_LEN]};

  assign keep_eff       = (keep_bits_i > KW'(XLEN)) ? KW'(XLEN) : keep_bits_i;
  assign addr_mask_wide = (AW1'(1) << keep_eff) - AW1'(1);
  assign kept_addr      = tc_iaddr_i & addr_mask_wide[XLEN-1:0];

  always_comb begin
    map_len = P_LEN'(BRANCH_MAP_LEN);
    if (branches_i == '0)                           map_len = P_LEN'(31);
    else if (branches_i == BRANCH_COUNT_LEN'(1))    map_len = P_LEN'(1);
    else if (branches_i <= BRANCH_COUNT_LEN'(9))    map_len = P_LEN'(9);
    else if (branches_i <= BRANCH_COUNT_LEN'(17))   map_len = P_LEN'(17);
    else if (branches_i <= BRANCH_COUNT_LEN'(25))   map_len = P_LEN'(25);
    else                                            map_len = P_LEN'(31);
  end

  assign map_mask_wide = (MW1'(1) << map_len) - MW1'(1);
  assign map_bits      = branch_map_i & map_mask_wide[BRANCH_MAP_LEN-1:0];

  assign cause_sel     = lc_tc_mux_i ? tc_cause_i     : lc_cause_i;
  assign tval_sel      = lc_tc_mux_i ? tc_tval_i      : lc_tval_i;
  assign interrupt_sel = lc_tc_mux_i ? tc_interrupt_i : lc_interrupt_i;
  assign trap_addr     = thaddr_i ? {tc_tvec_i, 2'b00} : lc_epc_i;
  assign branch_bit    = tc_branch_i ? !tc_branch_taken_i : 1'b1;

  assign addr_to_compress_o =
    (packet_format_i == F_SYNC && packet_f_sync_subformat_i == SF_TRAP) ? trap_addr : tc_iaddr_i;

  always_comb begin
    emit_d    = 1'b0;
    flush_d   = 1'b0;
    payload_d = '0;
    bits_d    = '0;
    pos       = '0;
    if (valid_i) begin
      case (packet_format_i)
        F_SYNC: begin
          emit_d         = 1'b1;
          payload_d[1:0] = packet_format_i;
          payload_d[3:2] = packet_f_sync_subformat_i;
          case (packet_f_sync_subformat_i)
            SF_START: begin
              payload_d[4]    = branch_bit;
              payload_d[6:5]  = tc_priv_i;
              payload_d[38:7] = tc_iaddr_i;
              bits_d          = P_LEN'(39);
            end
            SF_TRAP: begin
              payload_d[4]     = branch_bit;
              payload_d[6:5]   = tc_priv_i;
              payload_d[11:7]  = cause_sel;
              payload_d[12]    = interrupt_sel;
              payload_d[13]    = thaddr_i;
              payload_d[45:14] = trap_addr;
              payload_d[77:46] = tval_sel;
              bits_d           = P_LEN'(78);
            end
            SF_CONTEXT: begin
              payload_d[5:4] = tc_priv_i;
              bits_d         = P_LEN'(6);
            end
            default: begin
              payload_d[4]    = tc_ienable_i;
              payload_d[5]    = encoder_mode_i;
              payload_d[7:6]  = qual_status_i;
              payload_d[10:8] = ioptions_i;
              bits_d          = P_LEN'(11);
            end
          endcase
        end
        F_ADDR_ONLY: begin
          emit_d         = 1'b1;
          payload_d[1:0] = packet_format_i;
          payload_d      = payload_d | (PAYLOAD_LEN'(kept_addr) << 2);
          pos            = P_LEN'(2) + P_LEN'(keep_eff);
          payload_d      = payload_d | (PAYLOAD_LEN'(lc_updiscon_i) << pos);
          bits_d         = pos + P_LEN'(1);
        end
        F_BRANCH_FULL: begin
          emit_d         = 1'b1;
          flush_d        = 1'b1;
          payload_d[1:0] = packet_format_i;
          payload_d[6:2] = branches_i;
          payload_d      = payload_d | (PAYLOAD_LEN'(map_bits) << 7);
          pos            = P_LEN'(7) + map_len;
          // A zero count means a full map with nothing following it.
          if (branches_i != '0) begin
            payload_d = payload_d | (PAYLOAD_LEN'(kept_addr) << pos);
            pos       = pos + P_LEN'(keep_eff);
            payload_d = payload_d | (PAYLOAD_LEN'(lc_updiscon_i) << pos);
            pos       = pos + P_LEN'(1);
          end
          bits_d = pos;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      packet_valid_o     <= 1'b0;
      packet_payload_o   <= '0;
      payload_length_o   <= '0;
      branch_map_flush_o <= 1'b0;
    end else begin
      packet_valid_o     <= emit_d;
      packet_payload_o   <= payload_d;
      payload_length_o   <= (bits_d + P_LEN'(7)) >> 3;
      branch_map_flush_o <= flush_d;
    end
  end

endmodule

// File: tb/tb_trdb_packet_emitter.sv
// Directed bench for trdb_packet_emitter: each task applies hand-computed vectors
// and checks the registered packet one clock later.
module tb_trdb_packet_emitter;
  import trdb_pkg::*;

  logic                        clk_i;
  logic                        rst_ni;
  logic                        valid_i;
  trdb_format_e                packet_format_i;
  trdb_f_sync_subformat_e      packet_f_sync_subformat_i;
  logic [CAUSE_LEN-1:0]        lc_cause_i, tc_cause_i;
  logic [XLEN-1:0]             lc_tval_i, tc_tval_i;
  logic                        lc_interrupt_i, tc_interrupt_i, lc_tc_mux_i;
  logic                        nocontext_i, notime_i, tc_branch_i, tc_branch_taken_i;
  logic [1:0]                  tc_priv_i;
  logic [XLEN-1:0]             tc_iaddr_i;
  logic                        thaddr_i;
  logic [XLEN-3:0]             tc_tvec_i;
  logic [XLEN-1:0]             lc_epc_i;
  logic                        tc_ienable_i, encoder_mode_i;
  qual_status_e                qual_status_i;
  ioptions_e                   ioptions_i;
  logic                        lc_updiscon_i;
  logic [BRANCH_COUNT_LEN-1:0] branches_i;
  logic [BRANCH_MAP_LEN-1:0]   branch_map_i;
  logic [$clog2(XLEN):0]       keep_bits_i;
  logic                        packet_valid_o;
  logic [PAYLOAD_LEN-1:0]      packet_payload_o;
  logic [P_LEN-1:0]            payload_length_o;
  logic                        branch_map_flush_o;
  logic [XLEN-1:0]             addr_to_compress_o;

  int checks = 0;
  int errors = 0;
  logic [PAYLOAD_LEN-1:0] exp_pl;

  trdb_packet_emitter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i),
    .packet_format_i(packet_format_i), .packet_f_sync_subformat_i(packet_f_sync_subformat_i),
    .lc_cause_i(lc_cause_i), .tc_cause_i(tc_cause_i), .lc_tval_i(lc_tval_i), .tc_tval_i(tc_tval_i),
    .lc_interrupt_i(lc_interrupt_i), .tc_interrupt_i(tc_interrupt_i), .lc_tc_mux_i(lc_tc_mux_i),
    .nocontext_i(nocontext_i), .notime_i(notime_i), .tc_branch_i(tc_branch_i),
    .tc_branch_taken_i(tc_branch_taken_i), .tc_priv_i(tc_priv_i), .tc_iaddr_i(tc_iaddr_i),
    .thaddr_i(thaddr_i), .tc_tvec_i(tc_tvec_i), .lc_epc_i(lc_epc_i), .tc_ienable_i(tc_ienable_i),
    .encoder_mode_i(encoder_mode_i), .qual_status_i(qual_status_i), .ioptions_i(ioptions_i),
    .lc_updiscon_i(lc_updiscon_i), .branches_i(branches_i), .branch_map_i(branch_map_i),
    .keep_bits_i(keep_bits_i), .packet_valid_o(packet_valid_o), .packet_payload_o(packet_payload_o),
    .payload_length_o(payload_length_o), .branch_map_flush_o(branch_map_flush_o),
    .addr_to_compress_o(addr_to_compress_o)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic clear_inputs();
    valid_i = 1'b0; packet_format_i = F_UNSUPPORTED; packet_f_sync_subformat_i = SF_START;
    lc_cause_i = '0; tc_cause_i = '0; lc_tval_i = '0; tc_tval_i = '0;
    lc_interrupt_i = 1'b0; tc_interrupt_i = 1'b0; lc_tc_mux_i = 1'b0;
    nocontext_i = 1'b0; notime_i = 1'b0; tc_branch_i = 1'b0; tc_branch_taken_i = 1'b0;
    tc_priv_i = '0; tc_iaddr_i = '0; thaddr_i = 1'b0; tc_tvec_i = '0; lc_epc_i = '0;
    tc_ienable_i = 1'b0; encoder_mode_i = 1'b0; qual_status_i = QS_NO_CHANGE;
    ioptions_i = IOPT_DELTA; lc_updiscon_i = 1'b0; branches_i = '0; branch_map_i = '0;
    keep_bits_i = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    valid_i = 1'b1; packet_format_i = F_SYNC; tc_iaddr_i = 32'h1111_2222;
    rst_ni = 1'b0;
    repeat (2) step();
    checks++; if (packet_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", packet_valid_o); end
    checks++; if (packet_payload_o !== '0) begin errors++; $display("FAIL reset_payload: got %h want 0", packet_payload_o); end
    checks++; if (payload_length_o !== 8'd0) begin errors++; $display("FAIL reset_length: got %0d want 0", payload_length_o); end
    checks++; if (branch_map_flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", branch_map_flush_o); end
    checks++; if (addr_to_compress_o !== 32'h1111_2222) begin errors++; $display("FAIL reset_addr_follows: got %h want 11112222", addr_to_compress_o); end
    rst_ni = 1'b1;
    clear_inputs();
    step();
  endtask

  task automatic test_start();
    clear_inputs();
    valid_i = 1'b1; packet_format_i = F_SYNC; packet_f_sync_subformat_i = SF_START;
    tc_priv_i = 2'd3; tc_iaddr_i = 32'h8000_0000;
    step();
    exp_pl = '0; exp_pl[1:0] = 2'd3; exp_pl[4] = 1'b1; exp_pl[6:5] = 2'd3; exp_pl[38:7] = 32'h8000_0000;
    checks++; if (packet_valid_o !== 1'b1) begin errors++; $display("FAIL start_valid: got %b want 1", packet_valid_o); end
    checks++; if (packet_payload_o[4:0] !== 5'b10011) begin errors++; $display("FAIL start_header: got %b want 10011", packet_payload_o[4:0]); end
    checks++; if (packet_payload_o !== exp_pl) begin errors++; $display("FAIL start_payload: got %h want %h", packet_payload_o, exp_pl); end
    checks++; if (payload_length_o !== 8'd5) begin errors++; $display("FAIL start_length: got %0d want 5", payload_length_o); end
    checks++; if (branch_map_flush_o !== 1'b0) begin errors++; $display("FAIL start_flush: got %b want 0", branch_map_flush_o); end
    // taken branch clears the branch bit
    packet_f_sync_subformat_i = SF_START; tc_priv_i = 2'd1; tc_branch_i = 1'b1; tc_branch_taken_i = 1'b1;
    tc_iaddr_i = 32'h0000_1000;
    step();
    exp_pl = '0; exp_pl[1:0] = 2'd3; exp_pl[4] = 1'b0; exp_pl[6:5] = 2'd1; exp_pl[38:7] = 32'h0000_1000;
    checks++; if (packet_payload_o !== exp_pl) begin errors++; $display("FAIL start_taken_payload: got %h want %h", packet_payload_o, exp_pl); end
  endtask

  task automatic test_trap();
    clear_inputs();
    valid_i = 1'b1; packet_format_i = F_SYNC; packet_f_sync_subformat_i = SF_TRAP;
    thaddr_i = 1'b1; tc_tvec_i = 30'h2000_0000; lc_tc_mux_i = 1'b1; tc_cause_i = 5'd2;
    tc_interrupt_i = 1'b1; tc_tval_i = 32'hDEAD_BEEF; lc_cause_i = 5'd7; lc_tval_i = 32'h5555_5555;
    lc_epc_i = 32'h0000_4444; tc_priv_i = 2'd3; tc_iaddr_i = 32'h0000_0100;
    #1;
    checks++; if (addr_to_compress_o !== 32'h8000_0000) begin errors++; $display("FAIL trap_comp_addr: got %h want 80000000", addr_to_compress_o); end
    step();
    exp_pl = '0; exp_pl[1:0] = 2'd3; exp_pl[3:2] = 2'd1; exp_pl[4] = 1'b1; exp_pl[6:5] = 2'd3;
    exp_pl[11:7] = 5'd2; exp_pl[12] = 1'b1; exp_pl[13] = 1'b1; exp_pl[45:14] = 32'h8000_0000;
    exp_pl[77:46] = 32'hDEAD_BEEF;
    checks++; if (packet_payload_o[11:7] !== 5'd2) begin errors++; $display("FAIL trap_ecause: got %0d want 2", packet_payload_o[11:7]); end
    checks++; if (packet_payload_o[45:14] !== 32'h8000_0000) begin errors++; $display("FAIL trap_address: got %h want 80000000", packet_payload_o[45:14]); end
    checks++; if (packet_payload_o !== exp_pl) begin errors++; $display("FAIL trap_payload: got %h want %h", packet_payload_o, exp_pl); end
    checks++; if (payload_length_o !== 8'd10) begin errors++; $display("FAIL trap_length: got %0d want 10", payload_length_o); end
    // epc as address, last-cycle trap info
    thaddr_i = 1'b0; lc_tc_mux_i = 1'b0; lc_cause_i = 5'd5; lc_interrupt_i = 1'b0;
    lc_tval_i = 32'h1234_5678; tc_priv_i = 2'd0;
    #1;
    checks++; if (addr_to_compress_o !== 32'h0000_4444) begin errors++; $display("FAIL trap_epc_comp_addr: got %h want 00004444", addr_to_compress_o); end
    step();
    exp_pl = '0; exp_pl[1:0] = 2'd3; exp_pl[3:2] = 2'd1; exp_pl[4] = 1'b1;
    exp_pl[11:7] = 5'd5; exp_pl[45:14] = 32'h0000_4444; exp_pl[77:46] = 32'h1234_5678;
    checks++; if (packet_payload_o !== exp_pl) begin errors++; $display("FAIL trap_epc_payload: got %h want %h", packet_payload_o, exp_pl); end
  endtask

  task automatic test_context_support();
    clear_inputs();
    valid_i = 1'b1; packet_format_i = F_SYNC; packet_f_sync_subformat_i = SF_CONTEXT;
    tc_priv_i = 2'd2; tc_iaddr_i = 32'hCAFE_0000;
    step();
    checks++; if (packet_payload_o !== PAYLOAD_LEN'(8'h2B)) begin errors++; $display("FAIL context_payload: got %h want 2b", packet_payload_o); end
    checks++; if (payload_length_o !== 8'd1) begin errors++; $display("FAIL context_length: got %0d want 1", payload_length_o); end
    packet_f_sync_subformat_i = SF_SUPPORT; tc_ienable_i = 1'b1; encoder_mode_i = 1'b0;
    qual_status_i = QS_TRACE_LOST; ioptions_i = IOPT_BRANCH_PRED;
    #1;
    checks++; if (addr_to_compress_o !== 32'hCAFE_0000) begin errors++; $display("FAIL support_comp_addr: got %h want cafe0000", addr_to_compress_o); end
    step();
    checks++; if (packet_payload_o !== PAYLOAD_LEN'(16'h059F)) begin errors++; $display("FAIL support_payload: got %h want 59f", packet_payload_o); end
    checks++; if (payload_length_o !== 8'd2) begin errors++; $display("FAIL support_length: got %0d want 2", payload_length_o); end
  endtask

  task automatic test_addr_only();
    clear_inputs();
    valid_i = 1'b1; packet_format_i = F_ADDR_ONLY; keep_bits_i = 6'd0; lc_updiscon_i = 1'b1;
    tc_iaddr_i = 32'hFFFF_FFFF;
    step();
    checks++; if (packet_payload_o !== PAYLOAD_LEN'(3'b110)) begin errors++; $display("FAIL addr_keep0_payload: got %h want 6", packet_payload_o); end
    checks++; if (payload_length_o !== 8'd1) begin errors++; $display("FAIL addr_keep0_length: got %0d want 1", payload_length_o); end
    keep_bits_i = 6'd12; tc_iaddr_i = 32'h000A_BCDE;
    step();
    checks++; if (packet_payload_o !== PAYLOAD_LEN'(16'h737A)) begin errors++; $display("FAIL addr_keep12_payload: got %h want 737a", packet_payload_o); end
    checks++; if (payload_length_o !== 8'd2) begin errors++; $display("FAIL addr_keep12_length: got %0d want 2", payload_length_o); end
    keep_bits_i = 6'd40; tc_iaddr_i = 32'hF000_0001; lc_updiscon_i = 1'b0;
    step();
    checks++; if (packet_payload_o !== PAYLOAD_LEN'(40'h03_C000_0006)) begin errors++; $display("FAIL addr_clamp_payload: got %h want 3c0000006", packet_payload_o); end
    checks++; if (payload_length_o !== 8'd5) begin errors++; $display("FAIL addr_clamp_length: got %0d want 5", payload_length_o); end
    checks++; if (branch_map_flush_o !== 1'b0) begin errors++; $display("FAIL addr_flush: got %b want 0", branch_map_flush_o); end
  endtask

  task automatic test_branch();
    clear_inputs();
    valid_i = 1'b1; packet_format_i = F_BRANCH_FULL; branches_i = 5'd3; branch_map_i = 31'b101;
    keep_bits_i = 6'd8; tc_iaddr_i = 32'h0000_1234;
    step();
    checks++; if (packet_payload_o !== PAYLOAD_LEN'(32'h0034_028D)) begin errors++; $display("FAIL br3_payload: got %h want 34028d", packet_payload_o); end
    checks++; if (payload_length_o !== 8'd4) begin errors++; $display("FAIL br3_length: got %0d want 4", payload_length_o); end
    checks++; if (branch_map_flush_o !== 1'b1) begin errors++; $display("FAIL br3_flush: got %b want 1", branch_map_flush_o); end
    branches_i = 5'd0; branch_map_i = 31'h7FFF_FFFF;
    step();
    checks++; if (packet_payload_o !== PAYLOAD_LEN'(40'h3F_FFFF_FF81)) begin errors++; $display("FAIL br0_payload: got %h want 3fffffff81", packet_payload_o); end
    checks++; if (payload_length_o !== 8'd5) begin errors++; $display("FAIL br0_length: got %0d want 5", payload_length_o); end
    branches_i = 5'd1; keep_bits_i = 6'd4; tc_iaddr_i = 32'h0000_000A; lc_updiscon_i = 1'b1;
    step();
    checks++; if (packet_payload_o !== PAYLOAD_LEN'(16'h1A85)) begin errors++; $display("FAIL br1_payload: got %h want 1a85", packet_payload_o); end
    checks++; if (payload_length_o !== 8'd2) begin errors++; $display("FAIL br1_length: got %0d want 2", payload_length_o); end
    branches_i = 5'd9; keep_bits_i = 6'd0; lc_updiscon_i = 1'b0;
    step();
    checks++; if (packet_payload_o !== PAYLOAD_LEN'(16'hFFA5)) begin errors++; $display("FAIL br9_payload: got %h want ffa5", packet_payload_o); end
    checks++; if (payload_length_o !== 8'd3) begin errors++; $display("FAIL br9_length: got %0d want 3", payload_length_o); end
    branches_i = 5'd10;
    step();
    checks++; if (packet_payload_o !== PAYLOAD_LEN'(32'h00FF_FFA9)) begin errors++; $display("FAIL br10_payload: got %h want ffffa9", packet_payload_o); end
    checks++; if (payload_length_o !== 8'd4) begin errors++; $display("FAIL br10_length: got %0d want 4", payload_length_o); end
    branches_i = 5'd20; lc_updiscon_i = 1'b1;
    step();
    checks++; if (packet_payload_o !== PAYLOAD_LEN'(40'h01_FFFF_FFD1)) begin errors++; $display("FAIL br20_payload: got %h want 1ffffffd1", packet_payload_o); end
    checks++; if (payload_length_o !== 8'd5) begin errors++; $display("FAIL br20_length: got %0d want 5", payload_length_o); end
  endtask

  task automatic test_invalid();
    clear_inputs();
    valid_i = 1'b0; packet_format_i = F_BRANCH_FULL; branches_i = 5'd3; tc_iaddr_i = 32'h1;
    step();
    checks++; if (packet_valid_o !== 1'b0) begin errors++; $display("FAIL novalid_valid: got %b want 0", packet_valid_o); end
    checks++; if (branch_map_flush_o !== 1'b0) begin errors++; $display("FAIL novalid_flush: got %b want 0", branch_map_flush_o); end
    checks++; if (packet_payload_o !== '0) begin errors++; $display("FAIL novalid_payload: got %h want 0", packet_payload_o); end
    valid_i = 1'b1; packet_format_i = F_UNSUPPORTED;
    step();
    checks++; if (packet_valid_o !== 1'b0) begin errors++; $display("FAIL fmt0_valid: got %b want 0", packet_valid_o); end
    checks++; if (payload_length_o !== 8'd0) begin errors++; $display("FAIL fmt0_length: got %0d want 0", payload_length_o); end
    checks++; if (branch_map_flush_o !== 1'b0) begin errors++; $display("FAIL fmt0_flush: got %b want 0", branch_map_flush_o); end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    valid_i = 1'b1; packet_format_i = F_BRANCH_FULL; branches_i = 5'd3; branch_map_i = 31'b101;
    keep_bits_i = 6'd8; tc_iaddr_i = 32'h0000_1234;
    step();
    packet_format_i = F_SYNC; packet_f_sync_subformat_i = SF_CONTEXT; tc_priv_i = 2'd2;
    checks++; if (branch_map_flush_o !== 1'b1) begin errors++; $display("FAIL b2b_first_flush: got %b want 1", branch_map_flush_o); end
    step();
    checks++; if (branch_map_flush_o !== 1'b0) begin errors++; $display("FAIL b2b_second_flush: got %b want 0", branch_map_flush_o); end
    checks++; if (packet_payload_o !== PAYLOAD_LEN'(8'h2B)) begin errors++; $display("FAIL b2b_second_payload: got %h want 2b", packet_payload_o); end
    checks++; if (packet_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got %b want 1", packet_valid_o); end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    valid_i = 1'b1; packet_format_i = F_BRANCH_FULL; branches_i = 5'd3; branch_map_i = 31'b101;
    keep_bits_i = 6'd8; tc_iaddr_i = 32'h0000_1234;
    step();
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (packet_valid_o !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", packet_valid_o); end
    checks++; if (packet_payload_o !== '0) begin errors++; $display("FAIL async_payload: got %h want 0", packet_payload_o); end
    checks++; if (payload_length_o !== 8'd0) begin errors++; $display("FAIL async_length: got %0d want 0", payload_length_o); end
    checks++; if (branch_map_flush_o !== 1'b0) begin errors++; $display("FAIL async_flush: got %b want 0", branch_map_flush_o); end
    checks++; if (addr_to_compress_o !== 32'h0000_1234) begin errors++; $display("FAIL async_comp_addr: got %h want 1234", addr_to_compress_o); end
    step();
    #3 rst_ni = 1'b1;
    step();
    checks++; if (packet_payload_o !== PAYLOAD_LEN'(32'h0034_028D)) begin errors++; $display("FAIL resume_payload: got %h want 34028d", packet_payload_o); end
    checks++; if (branch_map_flush_o !== 1'b1) begin errors++; $display("FAIL resume_flush: got %b want 1", branch_map_flush_o); end
  endtask

  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    test_reset();
    test_start();
    test_trap();
    test_context_support();
    test_addr_only();
    test_branch();
    test_invalid();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trdb_packet_emitter.md
TRDB_PACKET_EMITTER -- requirements
Module: trdb_packet_emitter

Interface
REQ-001 SHALL take parameters from trdb_pkg: XLEN=32 (address width), CAUSE_LEN=5 (cause width), BRANCH_COUNT_LEN=5 (branch count width), BRANCH_MAP_LEN=31 (branch map width), PAYLOAD_LEN=256 (payload bus width), P_LEN=8 (byte-length width).
REQ-002 SHALL use one clock and an asynchronous, active-low reset: clk_i (in, 1, rising edge) and rst_ni (in, 1).
REQ-003 SHALL have these inputs (in):
- valid_i (1): packet request.
- packet_format_i (trdb_format_e, 2): packet format.
- packet_f_sync_subformat_i (trdb_f_sync_subformat_e, 2): sync subformat.
- lc_cause_i, tc_cause_i (CAUSE_LEN): last-cycle and this-cycle cause.
- lc_tval_i, tc_tval_i (XLEN): trap values.
- lc_interrupt_i, tc_interrupt_i (1): interrupt flags.
- lc_tc_mux_i (1): trap-info source select, 0 = lc_*, 1 = tc_*.
- nocontext_i, notime_i (1), tc_branch_i (1), tc_branch_taken_i (1), tc_priv_i (2).
- tc_iaddr_i (XLEN), thaddr_i (1), tc_tvec_i (XLEN-2: tvec[XLEN-1:2]), lc_epc_i (XLEN).
- tc_ienable_i (1), encoder_mode_i (1), qual_status_i (qual_status_e, 2), ioptions_i (ioptions_e, 3).
- lc_updiscon_i (1), branches_i (BRANCH_COUNT_LEN), branch_map_i (BRANCH_MAP_LEN).
- keep_bits_i ($clog2(XLEN)+1): address bits to keep after compression.
REQ-004 SHALL have these outputs (out):
- packet_valid_o (1).
- packet_payload_o (PAYLOAD_LEN): packed fields, first field at bit 0.
- payload_length_o (P_LEN): payload length in bytes, = ceil(bits/8).
- branch_map_flush_o (1).
- addr_to_compress_o (XLEN).

Function
REQ-005 SHALL register all outputs except addr_to_compress_o on rising clk_i, giving one-cycle latency from valid_i.
REQ-006 SHALL drive addr_to_compress_o combinationally:
- trap subformat: trap address (see REQ-009);
- otherwise: tc_iaddr_i.
REQ-007 SHALL pack every packet as format[1:0] at bits 1:0, then the remaining fields in listed order, contiguous, with unused upper bits 0.
REQ-008 Format 3, SF_START (0): subformat(2), branch = !tc_branch_taken_i when tc_branch_i else 1, priv(2), address = tc_iaddr_i (XLEN); length 4+1+2+XLEN bits.
REQ-009 Format 3, SF_TRAP (1): subformat, branch, priv, ecause(CAUSE_LEN), interrupt, thaddr_i, address, tval(XLEN). Sources:
- ecause/interrupt/tval from lc_* or tc_* per lc_tc_mux_i;
- address = {tc_tvec_i,2'b00} when thaddr_i=1, else lc_epc_i.
REQ-010 Format 3, SF_CONTEXT (2): subformat, priv(2).
REQ-011 Format 3, SF_SUPPORT (3): subformat, tc_ienable_i, encoder_mode_i, qual_status_i(2), ioptions_i(3).
REQ-012 Context and time fields SHALL always be omitted, regardless of nocontext_i/notime_i.
REQ-013 Format 2 (address only): address = tc_iaddr_i[keep_bits_i-1:0], then updiscon = lc_updiscon_i; length 2+keep_bits_i+1 bits.
REQ-014 Format 1 (branch):
- fields: branches_i, branch_map, address, updiscon;
- branch map length by count: 1→1, 2-9→9, 10-17→17, 18-25→25, 26-31→31 bits, taking the low bits of branch_map_i;
- branches_i=0: 31-bit map, no address and no updiscon.
REQ-015 branch_map_flush_o SHALL be 1 for exactly the cycle a format-1 packet is output, else 0.
REQ-016 Format 0 (unsupported) or valid_i=0: packet_valid_o=0, payload 0, length 0, flush 0.
REQ-017 keep_bits_i=0 SHALL yield an address-free packet; keep_bits_i>XLEN SHALL be clamped to XLEN.

Reset
REQ-018 While rst_ni=0, packet_valid_o, packet_payload_o, payload_length_o and branch_map_flush_o SHALL be 0 immediately (asynchronous).
REQ-019 Output SHALL resume normally on the first rising edge after rst_ni deasserts; addr_to_compress_o follows inputs regardless of reset.

Verification
REQ-020 Start: valid=1, fmt=3, sf=0, priv=3, branch=0, iaddr=0x80000000 -> next cycle valid=1, payload bits1:0=3, bits3:2=0, bit4=1, length=5 bytes.
REQ-021 Trap with thaddr=1, tvec=0x20000000, lc_tc_mux=1, tc_cause=2 -> address field 0x80000000, ecause field=2, addr_to_compress_o=0x80000000 same cycle.
REQ-022 Format 1, branches=3, map=0b101, keep_bits=8, iaddr=0x1234 -> payload=fmt1|3<<2|0x05<<7|0x34<<16, flush=1, length=4 bytes.
REQ-023 Format 2, keep_bits=0 -> length=1 byte, payload=0b010 | updiscon<<2.
REQ-024 rst_ni asserted mid-packet -> all registered outputs 0 without waiting for a clock edge.
REQ-025 valid=0 or fmt=0 -> packet_valid_o=0, branch_map_flush_o=0.
